// File: rtl/risc_prog_loader.sv
// Boot-time program loader: streams a length-prefixed byte image into instruction memory
// and keeps the core halted until the load is complete. Optional macro: LOADER_CHECKSUM_EN.
module risc_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_halt,
    output logic [15:0]       words_loaded
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       MAX_LIMIT = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_FLUSH,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [7:0]        len_hi;
    logic [15:0]       word_count;
    logic [1:0]        byte_pos;
    logic [23:0]       word_sr;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       header_len;
    logic              xfer;
    logic              start_ok;
    logic              len_too_big;
    logic              last_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign xfer        = in_valid & in_ready;
    assign start_ok    = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
    assign header_len  = {len_hi, in_data};
    assign len_too_big = ({16'd0, header_len} > MAX_LIMIT);
    assign last_byte   = (state == S_DATA) && xfer && (byte_pos == 2'd3) &&
                         ((words_loaded + 16'd1) == word_count);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Without a checksum the last word still needs its write cycle, so FLUSH holds
    // done low until mem_we has been issued.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    next_state = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    next_state = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (header_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        next_state = S_CSUM;
`else
                        next_state = S_DONE;
`endif
                    end else if (len_too_big) begin
                        next_state = S_ERR;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (last_byte) begin
`ifdef LOADER_CHECKSUM_EN
                    next_state = S_CSUM;
`else
                    next_state = S_FLUSH;
`endif
                end
            end
            S_FLUSH: begin
                next_state = S_DONE;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    next_state = (in_data == csum) ? S_DONE : S_ERR;
                end
            end
`endif
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_FLUSH: begin
                busy = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);
    assign cpu_halt = (state != S_DONE);

    // Bytes arrive MSB first; the first three are shifted in and the fourth completes
    // the word, which is written on the following cycle.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            words_loaded <= 16'd0;
            len_hi       <= 8'd0;
            word_count   <= 16'd0;
            byte_pos     <= 2'd0;
            word_sr      <= 24'd0;
            wr_addr      <= BASE;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                words_loaded <= 16'd0;
                byte_pos     <= 2'd0;
                wr_addr      <= BASE;
            end
            if ((state == S_LEN_HI) && xfer) begin
                len_hi <= in_data;
            end
            if ((state == S_LEN_LO) && xfer) begin
                word_count <= header_len;
            end
            if ((state == S_DATA) && xfer) begin
                byte_pos <= byte_pos + 2'd1;
                if (byte_pos == 2'd3) begin
                    mem_we       <= 1'b1;
                    mem_wdata    <= {word_sr, in_data};
                    mem_addr     <= wr_addr;
                    wr_addr      <= wr_addr + 1'b1;
                    words_loaded <= words_loaded + 16'd1;
                end else begin
                    word_sr <= {word_sr[15:0], in_data};
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'd0;
        end else if (start_ok) begin
            csum <= 8'd0;
        end else if ((state == S_DATA) && xfer) begin
            csum <= csum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_risc_prog_loader.sv
// Bench for risc_prog_loader: vector table of images plus reset, ignored-start and
// post-done sequences; memory writes are matched against a scoreboard queue.
module tb_risc_prog_loader;

    localparam int TB_ADDR_W = 10;
    localparam int TB_BASE   = 0;
    localparam int TB_MAX    = 1024;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic                 clk1;
    logic                 rst_n;
    logic                 start;
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 mem_we;
    logic [TB_ADDR_W-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 cpu_halt;
    logic [15:0]          words_loaded;

    risc_prog_loader #(
        .ADDR_W   (TB_ADDR_W),
        .BASE_ADDR(TB_BASE),
        .MAX_WORDS(TB_MAX)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cpu_halt    (cpu_halt),
        .words_loaded(words_loaded)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct {
        logic [TB_ADDR_W-1:0] addr;
        logic [31:0]          data;
    } wr_t;

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          gaps;
        bit          bad_csum;
        bit          exp_done;
        bit          exp_err;
        logic [15:0] exp_words;
    } vec_t;

    wr_t  exp_q[$];
    bit   we_due = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] n, input logic [31:0] w0,
                                input logic [31:0] w1, input bit gaps, input bit bad,
                                input bit exp_err, input logic [15:0] exp_words);
        vec_t v;
        v.n         = n;
        v.w0        = w0;
        v.w1        = w1;
        v.gaps      = gaps;
        v.bad_csum  = bad;
        v.exp_err   = exp_err;
        v.exp_done  = !exp_err;
        v.exp_words = exp_words;
        return v;
    endfunction

    function automatic logic [31:0] gen_word(input vec_t v, input int i);
        if (i == 0) return v.w0;
        if (i == 1) return v.w1;
        return {8'hC3, 8'(i) ^ 8'h5A, 16'(i)};
    endfunction

    function automatic logic [TB_ADDR_W-1:0] exp_addr(input int i);
        return TB_ADDR_W'((TB_BASE + i) % (1 << TB_ADDR_W));
    endfunction

    // Each write cycle must be the one right after a word's fourth byte, with done still low.
    always @(negedge clk1) begin
        if (rst_n && (mem_we || we_due)) begin
            wr_t e;
            check("write_strobe_timing", mem_we, we_due);
            check("done_low_during_write", done, 1'b0);
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", mem_addr, e.addr);
                    check("write_data", mem_wdata, e.data);
                end
            end
            we_due = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        repeat (gap) @(negedge clk1);
        @(negedge clk1);
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (in_ready) begin
                @(posedge clk1);
                ok = 1'b1;
            end else begin
                @(negedge clk1);
            end
        end
        #1 in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL byte_accept_timeout: got in_ready=0, expected 1 within 20 cycles");
        end
    endtask

    task automatic push_write(input int idx, input logic [31:0] w);
        wr_t e;
        e.addr = exp_addr(idx);
        e.data = w;
        exp_q.push_back(e);
        we_due = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk1);
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        check("start_clears_done", done, 1'b0);
        check("start_clears_err", err, 1'b0);
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_end(input string tag);
        int t = 0;
        @(negedge clk1);
        while (!(done || err) && t < 50) begin
            @(negedge clk1);
            t++;
        end
        #1;
        if (!(done || err)) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: got done=0 err=0, expected completion within 50 cycles", tag);
        end
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        check({tag, "_done"}, done, v.exp_done);
        check({tag, "_err"}, err, v.exp_err);
        check({tag, "_cpu_halt"}, cpu_halt, !v.exp_done);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_words_loaded"}, words_loaded, v.exp_words);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        logic [7:0]  cs = 8'd0;
        logic [7:0]  bt;
        logic [31:0] w;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        pulse_start();
        applyStimulus(v.n[15:8], v.gaps ? $urandom_range(0, 3) : 0);
        applyStimulus(v.n[7:0], v.gaps ? $urandom_range(0, 3) : 0);
        if (v.n <= TB_MAX) begin
            for (int i = 0; i < int'(v.n); i++) begin
                w = gen_word(v, i);
                for (int b = 0; b < 4; b++) begin
                    bt = w[31-8*b -: 8];
                    cs = cs ^ bt;
                    applyStimulus(bt, v.gaps ? $urandom_range(0, 3) : 0);
                end
                push_write(i, w);
            end
            if (CS_EN) begin
                applyStimulus(v.bad_csum ? (cs ^ 8'h01) : cs, 0);
            end
        end
        wait_end(tag);
        checkOutput(v, tag);
    endtask

    initial begin : main
        vec_t hv;

        vecs[0] = mk(16'd2,    32'h04221800, 32'h2485000A, 1'b0, 1'b0, 1'b0,  16'd2);
        vecs[1] = mk(16'd2,    32'h04221800, 32'h2485000A, 1'b1, 1'b0, 1'b0,  16'd2);
        vecs[2] = mk(16'd0,    32'h0,        32'h0,        1'b0, 1'b0, 1'b0,  16'd0);
        vecs[3] = mk(16'd1025, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1,  16'd0);
        vecs[4] = mk(16'd1,    32'h11223344, 32'h0,        1'b0, 1'b0, 1'b0,  16'd1);
        vecs[5] = mk(16'd1,    32'h11223344, 32'h0,        1'b1, 1'b1, CS_EN, 16'd1);
        vecs[6] = mk(16'd1024, 32'hDEADBEEF, 32'h0BADF00D, 1'b0, 1'b0, 1'b0,  16'd1024);
        vecs[7] = mk(16'd0,    32'h0,        32'h0,        1'b0, 1'b1, CS_EN, 16'd0);
        vecs[8] = mk(16'hFFFF, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1,  16'd0);

        rst_n    = 1'b0;
        start    = 1'b0;
        in_data  = 8'd0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk1);
        check("reset_cpu_halt", cpu_halt, 1'b1);
        check("reset_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;

        // Reset in the middle of the second word: one word written, one stray byte held.
        pulse_start();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h04, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'h18, 0);
        applyStimulus(8'h00, 0);
        push_write(0, 32'h04221800);
        applyStimulus(8'hAA, 0);
        @(negedge clk1);
        rst_n = 1'b0;
        #1;
        check("midreset_in_ready", in_ready, 1'b0);
        check("midreset_mem_we", mem_we, 1'b0);
        check("midreset_mem_addr", mem_addr, 0);
        check("midreset_mem_wdata", mem_wdata, 32'h0);
        check("midreset_busy", busy, 1'b0);
        check("midreset_done", done, 1'b0);
        check("midreset_err", err, 1'b0);
        check("midreset_cpu_halt", cpu_halt, 1'b1);
        check("midreset_words_loaded", words_loaded, 16'd0);
        check("midreset_pending_writes", exp_q.size(), 0);
        exp_q.delete();
        we_due = 1'b0;
        @(negedge clk1);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) begin
            run_vector(vecs[k], k);
        end

        // A start pulse while streaming data must not restart the load.
        pulse_start();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        @(negedge clk1);
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        check("ignored_start_busy", busy, 1'b1);
        applyStimulus(8'hDE, 0);
        applyStimulus(8'hAD, 0);
        push_write(0, 32'h1122DEAD);
        if (CS_EN) begin
            applyStimulus(8'h11 ^ 8'h22 ^ 8'hDE ^ 8'hAD, 0);
        end
        wait_end("ignored_start");
        hv = mk(16'd1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd1);
        checkOutput(hv, "ignored_start");

        // Bytes offered after DONE are refused and cause no write.
        @(negedge clk1);
        in_data  = 8'h55;
        in_valid = 1'b1;
        check("extra_byte_in_ready", in_ready, 1'b0);
        repeat (3) @(negedge clk1);
        in_valid = 1'b0;
        check("extra_byte_words_loaded", words_loaded, 16'd1);
        check("extra_byte_done", done, 1'b1);

        repeat (2) @(negedge clk1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
